sdram_cpu_bridge: RTL and testbench
===================================

// Module: sdram_cpu_bridge
// PURPOSE
//  CPU-side front end for one SDRAM controller channel (the ch3 port with byte enables).
//  Accepts word-addressed valid/ready requests, posts writes through a small FIFO, and holds one read word as a cache.
//  Converts each access into the controller's protocol: rising-edge req, address held stable, 1-cycle ready pulse.
//  Sits directly upstream of the SDRAM controller, between the core's memory decoder and its ch3 port.
// PARAMETERS
//  ADDR_W      24        CPU word-address width (cpu_addr[ADDR_W-1:0])
//  BASE_WORD   26'h0     word offset added to cpu_addr to form sdr_addr[26:1]
//  FIFO_DEPTH  4         posted-write FIFO entries (power of 2, >=2)
// PORTS
//  clk         in   1       single clock; all logic on posedge clk
//  reset_n     in   1       synchronous reset, active low
//  cpu_valid   in   1       request present
//  cpu_we      in   1       1=write, 0=read
//  cpu_addr    in   ADDR_W  word address
//  cpu_wdata   in   16      write data
//  cpu_be      in   2       byte enables {hi,lo}; must be nonzero for writes
//  cpu_ready   out  1       request accepted this cycle (valid&ready)
//  cpu_rvalid  out  1       1-cycle pulse: cpu_rdata valid
//  cpu_rdata   out  16      read data, held until next rvalid
//  flush       in   1       invalidate read buffer
//  sdr_addr    out  26      to controller chN_addr[26:1]
//  sdr_din     out  16      to controller chN_din
//  sdr_be      out  2       to controller chN_be
//  sdr_rnw     out  1       to controller chN_rnw
//  sdr_req     out  1       to controller chN_req (rising edge = new access)
//  sdr_ready   in   1       controller chN_ready pulse
//  sdr_dout    in   16      controller chN_dout, valid with sdr_ready
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): all outputs 0; FIFO empty; read buffer invalid; engine IDLE.
//   Reset mid-access drops sdr_req; any later stray sdr_ready is ignored while in IDLE.
//  Acceptance (cpu_ready, combinational from registered state only):
//   write: FIFO count < FIFO_DEPTH and no read outstanding.
//   read: FIFO empty, engine IDLE, no read outstanding. Reads never bypass posted writes.
//  Write accept: push {addr,wdata,be}; invalidate read buffer if its tag equals cpu_addr.
//  Read accept, buffer hit (valid & tag==cpu_addr): cpu_rvalid next cycle, no SDRAM access.
//  Read accept, miss: cpu_rdata <= sdr_dout and cpu_rvalid the cycle after sdr_ready; buffer loads tag+data.
//  Engine FSM: IDLE -> ISSUE -> GAP -> IDLE.
//   IDLE: if read miss pending, or FIFO non-empty (write), latch sdr_addr/din/be/rnw; sdr_req<=1; ->ISSUE.
//    Read miss has priority, but by the acceptance rule it only exists with FIFO empty.
//   ISSUE: hold sdr_req=1 and all sdr_* stable until sdr_ready; on sdr_ready: sdr_req<=0, pop FIFO (write);
//    capture data (read); ->GAP.
//   GAP: sdr_req stays 0 for exactly one cycle (controller edge detect needs a low sample); ->IDLE.
//  sdr_addr = BASE_WORD + zero-extended cpu_addr, modulo 2^26 (wraps silently).
//  Reads drive sdr_be=2'b11. Write sdr_ready pulses as the command issues; the next access may start after GAP.
//  FIFO full with a simultaneous pop: cpu_ready stays low that cycle (count is registered).
//  Write accepted and popped in the same cycle: count unchanged.
//  flush: buffer invalid next cycle. Flush with a same-cycle read miss completing: the flush wins and the buffer stays invalid.
//  Outstanding read plus flush: data is still returned to the CPU.
// STRUCTURE
//  Package sdram_bridge_pkg: eng_state_t enum {IDLE,ISSUE,GAP}; wr_entry_t struct {addr,data,be};
//   SDR_ADDR_W=26 constant.
//  Sub-module sdram_wr_fifo: synchronous FIFO of wr_entry_t, depth FIFO_DEPTH, with count/full/empty.
//  Top holds the acceptance logic, read buffer, and engine FSM.
// TESTING
//  1 Read miss addr 0x000123, controller model ready 7 cycles after req edge, dout=16'hBEEF
//   -> sdr_addr=0x000123, cpu_rvalid 1 cycle after ready, rdata=BEEF.
//  2 Repeat the read of 0x000123 -> rvalid next cycle, sdr_req never rises.
//   Then flush and read again -> SDRAM access occurs.
//  3 Five back-to-back writes with FIFO_DEPTH=4 and a slow controller
//   -> 5th stalls (cpu_ready=0) until the first pop; all 5 issue in order.
//   sdr_req low for >=1 cycle between each.
//  4 Write be=2'b10 to the cached word 0x10, then read 0x10 -> buffer invalidated.
//   The read issues only after the write's sdr_ready, with sdr_rnw=1 and sdr_be=2'b11.
//  5 BASE_WORD=26'h3FFFFFF, cpu_addr=1 -> sdr_addr=26'h0000000 (wrap).
//  6 Assert reset_n=0 during ISSUE -> sdr_req=0 next cycle.
//   A stray sdr_ready afterwards produces no rvalid and no FIFO change.

Source files
------------

// File: rtl/sdram_bridge_pkg.sv
// Shared types for the CPU-to-SDRAM bridge: engine states and the posted-write entry.
package sdram_bridge_pkg;

  localparam int SDR_ADDR_W = 26;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } eng_state_t;

  // Address is stored already mapped into controller word space
  typedef struct packed {
    logic [SDR_ADDR_W-1:0] addr;
    logic [15:0]           data;
    logic [1:0]            be;
  } wr_entry_t;

endpackage

// File: rtl/sdram_wr_fifo.sv
// Posted-write FIFO; count is registered so a full FIFO cannot accept in the pop cycle.
module sdram_wr_fifo
  import sdram_bridge_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  wr_entry_t     wr_entry,
  input  logic          pop,
  output wr_entry_t     head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  wr_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sdram_cpu_bridge.sv
// CPU front end for one SDRAM controller channel: posted writes, one-word read
// buffer, and a req/ready engine that leaves a low cycle between accesses.
module sdram_cpu_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int                    ADDR_W     = 24,
  parameter logic [SDR_ADDR_W-1:0] BASE_WORD  = 26'h0,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  input  logic [1:0]        cpu_be,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [15:0]       cpu_rdata,
  input  logic              flush,
  output logic [25:0]       sdr_addr,
  output logic [15:0]       sdr_din,
  output logic [1:0]        sdr_be,
  output logic              sdr_rnw,
  output logic              sdr_req,
  input  logic              sdr_ready,
  input  logic [15:0]       sdr_dout
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  eng_state_t        state;
  wr_entry_t         fifo_in;
  wr_entry_t         fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              accept_wr;
  logic              accept_rd;
  logic              buf_hit;
  logic              rd_pending;
  logic              rd_busy;
  logic [ADDR_W-1:0] rd_tag;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_tag;
  logic [15:0]       buf_data;

  // Acceptance depends only on registered state; gated by reset so nothing is taken during it
  assign cpu_ready = reset_n && cpu_valid &&
                     (cpu_we ? ((fifo_count < CW'(FIFO_DEPTH)) && !rd_busy)
                             : (fifo_empty && (state == IDLE) && !rd_busy));
  assign accept_wr = cpu_ready && cpu_we;
  assign accept_rd = cpu_ready && !cpu_we;
  assign buf_hit   = buf_valid && (buf_tag == cpu_addr);
  assign fifo_in   = '{addr: BASE_WORD + SDR_ADDR_W'(cpu_addr), data: cpu_wdata, be: cpu_be};
  assign fifo_pop  = (state == ISSUE) && sdr_ready && !sdr_rnw;

  sdram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (accept_wr),
    .wr_entry (fifo_in),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      sdr_addr   <= '0;
      sdr_din    <= '0;
      sdr_be     <= '0;
      sdr_rnw    <= 1'b0;
      sdr_req    <= 1'b0;
      rd_pending <= 1'b0;
      rd_busy    <= 1'b0;
      rd_tag     <= '0;
      buf_valid  <= 1'b0;
      buf_tag    <= '0;
      buf_data   <= '0;
    end else begin
      cpu_rvalid <= 1'b0;

      if (accept_wr && buf_hit) buf_valid <= 1'b0;

      if (accept_rd) begin
        if (buf_hit) begin
          cpu_rvalid <= 1'b1;
          cpu_rdata  <= buf_data;
        end else begin
          rd_pending <= 1'b1;
          rd_busy    <= 1'b1;
          rd_tag     <= cpu_addr;
        end
      end

      // A pending read miss can only coexist with an empty FIFO, so checking it first is safe
      case (state)
        IDLE: begin
          if (rd_pending) begin
            sdr_addr   <= BASE_WORD + SDR_ADDR_W'(rd_tag);
            sdr_din    <= '0;
            sdr_be     <= 2'b11;
            sdr_rnw    <= 1'b1;
            sdr_req    <= 1'b1;
            rd_pending <= 1'b0;
            state      <= ISSUE;
          end else if (!fifo_empty) begin
            sdr_addr <= fifo_head.addr;
            sdr_din  <= fifo_head.data;
            sdr_be   <= fifo_head.be;
            sdr_rnw  <= 1'b0;
            sdr_req  <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (sdr_ready) begin
            sdr_req <= 1'b0;
            if (sdr_rnw) begin
              cpu_rdata  <= sdr_dout;
              cpu_rvalid <= 1'b1;
              buf_valid  <= 1'b1;
              buf_tag    <= rd_tag;
              buf_data   <= sdr_dout;
              rd_busy    <= 1'b0;
            end
            state <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase

      // Flush is last so it overrides a fill landing in the same cycle
      if (flush) buf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// Self-checking bench: controller model with configurable latency, directed
// vector table, hand-written corner sequences and a random scoreboard phase.
module tb_sdram_cpu_bridge;

  logic        clk = 1'b0;
  logic        reset_n, cpu_valid, cpu_we, flush;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [1:0]  cpu_be;
  logic        cpu_ready, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic [25:0] sdr_addr;
  logic [15:0] sdr_din;
  logic [1:0]  sdr_be;
  logic        sdr_rnw, sdr_req;
  logic        sdr_ready = 1'b0;
  logic [15:0] sdr_dout  = '0;

  logic        w_cpu_ready, w_cpu_rvalid, w_sdr_rnw, w_sdr_req;
  logic [15:0] w_cpu_rdata, w_sdr_din;
  logic [25:0] w_sdr_addr;
  logic [1:0]  w_sdr_be;

  always #5 clk = ~clk;

  sdram_cpu_bridge dut (
    .clk(clk), .reset_n(reset_n), .cpu_valid(cpu_valid), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .flush(flush), .sdr_addr(sdr_addr), .sdr_din(sdr_din), .sdr_be(sdr_be),
    .sdr_rnw(sdr_rnw), .sdr_req(sdr_req), .sdr_ready(sdr_ready), .sdr_dout(sdr_dout)
  );

  // Same stimulus, offset base: only the mapped address may differ
  sdram_cpu_bridge #(.BASE_WORD(26'h3FFFFFF)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .cpu_valid(cpu_valid), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_ready(w_cpu_ready), .cpu_rvalid(w_cpu_rvalid), .cpu_rdata(w_cpu_rdata),
    .flush(flush), .sdr_addr(w_sdr_addr), .sdr_din(w_sdr_din), .sdr_be(w_sdr_be),
    .sdr_rnw(w_sdr_rnw), .sdr_req(w_sdr_req), .sdr_ready(sdr_ready), .sdr_dout(sdr_dout)
  );

  typedef struct {
    logic        rnw;
    logic [25:0] addr;
    logic [15:0] din;
    logic [1:0]  be;
    int          edge_cyc;
    int          done_cyc;
  } cmd_t;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rdata;
    int          exp_access;
  } vec_t;

  cmd_t        cmd_q[$];
  cmd_t        cur;
  logic [15:0] mem[int];
  logic [15:0] exp_q[$];
  logic [15:0] gold[16];
  int  cyc = 0, lat = 3, cnt = 0, req_edges = 0;
  int  stab_err = 0, rdbe_err = 0, shadow_err = 0, rvalid_cnt = 0;
  int  n_cmp = 0, n_err = 0;
  bit  busy = 0, sb_on = 0;
  logic req_q = 1'b0;

  function automatic logic [15:0] init_val(input logic [25:0] a);
    return {a[7:0], ~a[7:0]};
  endfunction

  function automatic logic [15:0] mem_rd(input logic [25:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return init_val(a);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
    return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
  endfunction

  // Controller model: rising req starts an access, ready pulses lat cycles later
  always @(posedge clk) begin
    cyc++;
    sdr_ready <= 1'b0;
    req_q     <= sdr_req;
    if (busy && sdr_req === 1'b1 &&
        (sdr_addr !== cur.addr || sdr_rnw !== cur.rnw || sdr_be !== cur.be || sdr_din !== cur.din))
      stab_err++;
    if (sdr_req === 1'b1 && req_q === 1'b0) begin
      cur = '{sdr_rnw, sdr_addr, sdr_din, sdr_be, cyc, -1};
      if (sdr_rnw && sdr_be != 2'b11) rdbe_err++;
      cmd_q.push_back(cur);
      req_edges++;
      busy = 1;
      cnt  = lat;
    end else if (busy) begin
      cnt--;
      if (cnt <= 0) begin
        busy = 0;
        sdr_ready <= 1'b1;
        if (cur.rnw) sdr_dout <= mem_rd(cur.addr);
        else mem[int'(cur.addr)] = merge(mem_rd(cur.addr), cur.din, cur.be);
        cmd_q[cmd_q.size()-1].done_cyc = cyc;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cpu_rvalid === 1'b1) rvalid_cnt++;
    if ({w_cpu_ready, w_cpu_rvalid, w_cpu_rdata, w_sdr_din, w_sdr_be, w_sdr_rnw, w_sdr_req} !==
        {cpu_ready, cpu_rvalid, cpu_rdata, sdr_din, sdr_be, sdr_rnw, sdr_req})
      shadow_err++;
    if (sb_on && cpu_rvalid === 1'b1) begin
      if (exp_q.size() == 0) checkOutput("sb_unexpected_rvalid", 32'd1, 32'd0);
      else checkOutput("sb_rdata", 32'(cpu_rdata), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one request and holds it until accepted or the bound expires
  task automatic applyStimulus(input logic we, input logic [23:0] addr, input logic [15:0] wdata,
                               input logic [1:0] be, output bit ok, output int acc_cyc, output int waited);
    ok = 0; acc_cyc = -1; waited = 0;
    cpu_valid = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    while (!ok && waited < 300) begin
      @(negedge clk);
      if (cpu_ready === 1'b1) begin
        ok = 1;
        acc_cyc = cyc;
      end else waited++;
      @(posedge clk);
      #1;
    end
    cpu_valid = 1'b0;
  endtask

  task automatic waitRvalid(output bit got, output logic [15:0] data, output int rv_cyc);
    got = 0; data = '0; rv_cyc = -1;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (cpu_rvalid === 1'b1) begin
        got = 1;
        data = cpu_rdata;
        rv_cyc = cyc;
      end
    end
  endtask

  task automatic waitReq(output bit seen);
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (sdr_req === 1'b1) seen = 1;
    end
  endtask

  task automatic pulseFlush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  initial begin
    vec_t        vecs[12];
    bit          ok, got;
    int          acc, wt, rv, e0, n0, r0;
    int          acc5[5], wt5[5];
    logic [15:0] d;
    logic [3:0]  idx;
    logic [1:0]  be;
    logic        we;

    vecs[0]  = '{1'b1, 24'h10, 16'h1234, 2'b11, 16'h0000, 1};
    vecs[1]  = '{1'b0, 24'h10, 16'h0000, 2'b11, 16'h1234, 1};
    vecs[2]  = '{1'b0, 24'h10, 16'h0000, 2'b11, 16'h1234, 0};
    vecs[3]  = '{1'b1, 24'h10, 16'hABCD, 2'b10, 16'h0000, 1};
    vecs[4]  = '{1'b0, 24'h10, 16'h0000, 2'b11, 16'hAB34, 1};
    vecs[5]  = '{1'b1, 24'h20, 16'h5566, 2'b01, 16'h0000, 1};
    vecs[6]  = '{1'b0, 24'h20, 16'h0000, 2'b11, 16'h2066, 1};
    vecs[7]  = '{1'b0, 24'h21, 16'h0000, 2'b11, 16'h21DE, 1};
    vecs[8]  = '{1'b0, 24'h20, 16'h0000, 2'b11, 16'h2066, 1};
    vecs[9]  = '{1'b1, 24'h21, 16'h0F0F, 2'b11, 16'h0000, 1};
    vecs[10] = '{1'b0, 24'h21, 16'h0000, 2'b11, 16'h0F0F, 1};
    vecs[11] = '{1'b0, 24'h21, 16'h0000, 2'b11, 16'h0F0F, 0};
    for (int i = 0; i < 16; i++) gold[i] = init_val(26'h40 + 26'(i));
    mem[32'h123] = 16'hBEEF;

    reset_n = 1'b0; cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h5; cpu_wdata = '0;
    cpu_be = 2'b11; flush = 1'b0;
    tick(3);
    @(negedge clk);
    checkOutput("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    checkOutput("rst_outputs", {cpu_rvalid, sdr_req, sdr_rnw, sdr_be, 11'd0, cpu_rdata}, 32'd0);
    checkOutput("rst_sdr_addr", 32'(sdr_addr), 32'd0);
    checkOutput("rst_sdr_din", 32'(sdr_din), 32'd0);
    tick(1);
    cpu_valid = 1'b0; reset_n = 1'b1;
    tick(2);

    $display("[TB] read miss with slow controller");
    lat = 7; n0 = cmd_q.size();
    applyStimulus(1'b0, 24'h123, 16'h0, 2'b11, ok, acc, wt);
    checkOutput("t1_accept", 32'(ok), 32'd1);
    waitRvalid(got, d, rv);
    tick(1);
    checkOutput("t1_rvalid", 32'(got), 32'd1);
    checkOutput("t1_rdata", 32'(d), 32'hBEEF);
    checkOutput("t1_cmd_count", 32'(cmd_q.size()), 32'(n0 + 1));
    if (cmd_q.size() > n0) begin
      checkOutput("t1_sdr_addr", 32'(cmd_q[n0].addr), 32'h123);
      checkOutput("t1_rnw_be", {cmd_q[n0].rnw, cmd_q[n0].be}, 32'b111);
      checkOutput("t1_rvalid_timing", 32'(rv), 32'(cmd_q[n0].done_cyc + 1));
    end

    $display("[TB] buffer hit, then flush");
    e0 = req_edges;
    applyStimulus(1'b0, 24'h123, 16'h0, 2'b11, ok, acc, wt);
    waitRvalid(got, d, rv);
    tick(12);
    checkOutput("t2_hit_rdata", 32'(d), 32'hBEEF);
    checkOutput("t2_hit_timing", 32'(rv), 32'(acc + 1));
    checkOutput("t2_hit_no_access", 32'(req_edges - e0), 32'd0);
    pulseFlush();
    applyStimulus(1'b0, 24'h123, 16'h0, 2'b11, ok, acc, wt);
    waitRvalid(got, d, rv);
    tick(1);
    checkOutput("t2_flush_rdata", 32'(d), 32'hBEEF);
    checkOutput("t2_flush_access", 32'(req_edges - e0), 32'd1);

    $display("[TB] vector table");
    lat = 3;
    for (int i = 0; i < 12; i++) begin
      e0 = req_edges;
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, ok, acc, wt);
      checkOutput($sformatf("vec%0d_accept", i), 32'(ok), 32'd1);
      if (!vecs[i].we) begin
        waitRvalid(got, d, rv);
        tick(1);
        checkOutput($sformatf("vec%0d_rvalid", i), 32'(got), 32'd1);
        checkOutput($sformatf("vec%0d_rdata", i), 32'(d), 32'(vecs[i].exp_rdata));
      end
      tick(20);
      checkOutput($sformatf("vec%0d_access", i), 32'(req_edges - e0), 32'(vecs[i].exp_access));
    end

    $display("[TB] five back-to-back writes");
    lat = 10; n0 = cmd_q.size();
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 24'h30 + 24'(i), 16'hC000 + 16'(i), 2'b11, ok, acc5[i], wt5[i]);
    tick(100);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("t3_wait%0d", i), 32'(wt5[i]), 32'd0);
    checkOutput("t3_cmd_count", 32'(cmd_q.size()), 32'(n0 + 5));
    if (cmd_q.size() >= n0 + 5) begin
      checkOutput("t3_fifth_accept", 32'(acc5[4]), 32'(cmd_q[n0].done_cyc + 1));
      for (int i = 0; i < 5; i++) begin
        checkOutput($sformatf("t3_addr%0d", i), 32'(cmd_q[n0+i].addr), 32'h30 + 32'(i));
        checkOutput($sformatf("t3_data%0d", i), {15'd0, cmd_q[n0+i].rnw, cmd_q[n0+i].din},
                    32'hC000 + 32'(i));
      end
      for (int i = 1; i < 5; i++)
        checkOutput($sformatf("t3_gap%0d", i),
                    32'(cmd_q[n0+i].edge_cyc >= cmd_q[n0+i-1].done_cyc + 2), 32'd1);
    end

    $display("[TB] write to cached word then read");
    lat = 3;
    pulseFlush();
    applyStimulus(1'b0, 24'h10, 16'h0, 2'b11, ok, acc, wt);
    waitRvalid(got, d, rv);
    tick(1);
    e0 = req_edges; n0 = cmd_q.size();
    applyStimulus(1'b0, 24'h10, 16'h0, 2'b11, ok, acc, wt);
    waitRvalid(got, d, rv);
    tick(1);
    checkOutput("t4_cached", 32'(req_edges - e0), 32'd0);
    applyStimulus(1'b1, 24'h10, 16'h9900, 2'b10, ok, acc, wt);
    applyStimulus(1'b0, 24'h10, 16'h0, 2'b11, ok, acc, wt);
    waitRvalid(got, d, rv);
    tick(1);
    checkOutput("t4_rdata", 32'(d), 32'h9934);
    checkOutput("t4_cmd_count", 32'(cmd_q.size()), 32'(n0 + 2));
    if (cmd_q.size() >= n0 + 2) begin
      checkOutput("t4_write_cmd", {cmd_q[n0].rnw, cmd_q[n0].be}, 32'b010);
      checkOutput("t4_read_cmd", {cmd_q[n0+1].rnw, cmd_q[n0+1].be}, 32'b111);
      checkOutput("t4_read_after_ready", 32'(cmd_q[n0+1].edge_cyc > cmd_q[n0].done_cyc), 32'd1);
    end

    $display("[TB] base offset wrap");
    pulseFlush();
    applyStimulus(1'b0, 24'h1, 16'h0, 2'b11, ok, acc, wt);
    waitReq(got);
    checkOutput("t5_req_seen", 32'(got), 32'd1);
    checkOutput("t5_sdr_addr", 32'(sdr_addr), 32'h1);
    checkOutput("t5_wrap_addr", 32'(w_sdr_addr), 32'h0);
    waitRvalid(got, d, rv);
    tick(1);
    checkOutput("t5_rdata", 32'(d), 32'h01FE);

    $display("[TB] reset during access");
    lat = 8;
    pulseFlush();
    applyStimulus(1'b0, 24'h7, 16'h0, 2'b11, ok, acc, wt);
    waitReq(got);
    checkOutput("t6_req_seen", 32'(got), 32'd1);
    tick(2);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("t6_req_dropped", 32'(sdr_req), 32'd0);
    e0 = req_edges; r0 = rvalid_cnt;
    tick(20);
    checkOutput("t6_stray_sent", 32'(cmd_q[cmd_q.size()-1].done_cyc != -1), 32'd1);
    checkOutput("t6_no_rvalid", 32'(rvalid_cnt - r0), 32'd0);
    checkOutput("t6_no_access", 32'(req_edges - e0), 32'd0);

    $display("[TB] random traffic");
    sb_on = 1;
    for (int t = 0; t < 250; t++) begin
      we  = ($urandom_range(0, 2) != 0);
      idx = 4'($urandom_range(0, 15));
      be  = 2'($urandom_range(1, 3));
      d   = 16'($urandom);
      lat = $urandom_range(1, 6);
      flush = ($urandom_range(0, 7) == 0);
      applyStimulus(we, 24'h40 + 24'(idx), d, be, ok, acc, wt);
      flush = 1'b0;
      checkOutput("rnd_accept", 32'(ok), 32'd1);
      if (ok) begin
        if (we) gold[idx] = merge(gold[idx], d, be);
        else exp_q.push_back(gold[idx]);
      end
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 4));
    end
    for (int n = 0; n < 500 && exp_q.size() != 0; n++) tick(1);
    checkOutput("rnd_drain", 32'(exp_q.size()), 32'd0);
    sb_on = 0;
    tick(80);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("rnd_mem%0d", i), 32'(mem_rd(26'h40 + 26'(i))), 32'(gold[i]));

    checkOutput("stable_during_issue", 32'(stab_err), 32'd0);
    checkOutput("read_be_11", 32'(rdbe_err), 32'd0);
    checkOutput("wrap_instance_match", 32'(shadow_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
